alu_unit: RTL and testbench



---
 rtl/alu_unit_pkg.sv | 16 +
 rtl/alu_adder.sv | 23 ++
 rtl/alu_unit.sv | 82 ++++++++
 tb/tb_alu_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_unit_pkg.sv
// Shared constants for the ALU: operation encodings and status-flag bit positions.
package alu_unit_pkg;

  localparam int unsigned ALU_W = 32;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_ORR = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_adder.sv
// 32-bit adder with carry-in; reports carry-out and signed overflow of the sum.
module alu_adder
  import alu_unit_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             cin,
  output logic [ALU_W-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [ALU_W:0] sum_ext;

  // 33-bit sum keeps the carry out of bit 31; overflow when like-signed inputs give an unlike-signed result
  always_comb begin
    sum_ext = {1'b0, a} + {1'b0, b} + {{ALU_W{1'b0}}, cin};
    sum     = sum_ext[ALU_W-1:0];
    cout    = sum_ext[ALU_W];
    ovf     = (a[ALU_W-1] == b[ALU_W-1]) && (sum_ext[ALU_W-1] != a[ALU_W-1]);
  end

endmodule

// File: rtl/alu_unit.sv
// Datapath ALU: AND/ORR/ADD/SUB with combinational NZCV and a registered status word
// updated under separate N/Z and C/V write enables.
module alu_unit
  import alu_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [ALU_W-1:0] SrcA,
  input  logic [ALU_W-1:0] SrcB,
  input  logic [1:0]       ALUcontrol,
  input  logic [1:0]       FlagWrite,
  output logic [ALU_W-1:0] ALUResult,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic [3:0]       Flags
);

  logic [ALU_W-1:0] add_b;
  logic [ALU_W-1:0] add_sum;
  logic             add_cout;
  logic             add_ovf;
  logic             is_arith;
  logic [3:0]       flags_d;
  logic [3:0]       flags_q;

  // SUB reuses the adder as SrcA + ~SrcB + 1, selected by the low opcode bit
  assign add_b    = ALUcontrol[0] ? ~SrcB : SrcB;
  assign is_arith = ALUcontrol[1];

  alu_adder u_adder (
    .a    (add_b ^ add_b ^ SrcA),
    .b    (add_b),
    .cin  (ALUcontrol[0]),
    .sum  (add_sum),
    .cout (add_cout),
    .ovf  (add_ovf)
  );

  // Result mux over logic ops and the shared adder
  always_comb begin
    ALUResult = '0;
    case (ALUcontrol)
      ALU_AND: ALUResult = SrcA & SrcB;
      ALU_ORR: ALUResult = SrcA | SrcB;
      ALU_ADD: ALUResult = add_sum;
      ALU_SUB: ALUResult = add_sum;
      default: ALUResult = '0;
    endcase
  end

  // Condition flags; C and V are forced low for the logic ops
  always_comb begin
    Negative = ALUResult[ALU_W-1];
    Zero     = (ALUResult == '0);
    Carry    = is_arith & add_cout;
    Overflow = is_arith & add_ovf;
  end

  // Next status word: each pair loads only when its write enable is set
  always_comb begin
    flags_d = flags_q;
    if (FlagWrite[1]) begin
      flags_d[FLAG_N] = Negative;
      flags_d[FLAG_Z] = Zero;
    end
    if (FlagWrite[0]) begin
      flags_d[FLAG_C] = Carry;
      flags_d[FLAG_V] = Overflow;
    end
  end

  // Status register; reset clears it immediately and overrides any edge update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

  assign Flags = flags_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: scoreboard queues hold expected combinational
// results and expected status-register contents until the DUT output is sampled.
module tb_alu_unit;

  logic        clk;
  logic        reset;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [1:0]  ALUcontrol;
  logic [1:0]  FlagWrite;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Negative;
  logic        Carry;
  logic        Overflow;
  logic [3:0]  Flags;

  int checks = 0;
  int errors = 0;

  // expected {ALUResult, N, Z, C, V}
  logic [35:0] comb_q[$];
  logic [3:0]  flag_q[$];

  alu_unit dut (
    .clk        (clk),
    .reset      (reset),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUcontrol (ALUcontrol),
    .FlagWrite  (FlagWrite),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .Negative   (Negative),
    .Carry      (Carry),
    .Overflow   (Overflow),
    .Flags      (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Reference model built on 64-bit signed arithmetic, independent of the adder structure
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
    logic [31:0] r;
    logic        c, v;
    longint      t;
    r = '0; c = 1'b0; v = 1'b0; t = 0;
    case (op)
      2'b00: r = a & b;
      2'b01: r = a | b;
      2'b10: begin
        t = longint'($signed(a)) + longint'($signed(b));
        r = a + b;
        c = (longint'({32'h0, a}) + longint'({32'h0, b})) > 64'sh0_FFFF_FFFF;
        v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      default: begin
        t = longint'($signed(a)) - longint'($signed(b));
        r = a - b;
        c = (a >= b);
        v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
    endcase
    return {r, r[31], (r == 32'h0), c, v};
  endfunction

  task automatic test_reset();
    reset = 1'b1; SrcA = '0; SrcB = '0; ALUcontrol = 2'b00; FlagWrite = 2'b00;
    flag_q.push_back(4'b0000);
    #1;
    checks++;
    if (Flags !== flag_q.pop_front()) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", Flags);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_hand_cases();
    logic [31:0] ta[13] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'h80000000, 32'h7FFFFFFF,
                            32'h80000000, 32'd7, 32'hFFFFFFFF, 32'd3, 32'hFFFF0000,
                            32'h0, 32'h0000FFFF};
    logic [31:0] tb[13] = '{32'd4, 32'd4, 32'd4, 32'd4, 32'h00000001, 32'h7FFFFFFF,
                            32'h7FFFFFFF, 32'd7, 32'd1, 32'd5, 32'h8000FFFF,
                            32'h0, 32'h00000001};
    logic [1:0]  to[13] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10,
                            2'b11, 2'b11, 2'b10, 2'b11, 2'b00,
                            2'b01, 2'b11};
    logic [35:0] te[13] = '{{32'h4, 4'b0000}, {32'h5, 4'b0000}, {32'h9, 4'b0000},
                            {32'h1, 4'b0010}, {32'h7FFFFFFF, 4'b0011},
                            {32'hFFFFFFFE, 4'b1001}, {32'h1, 4'b0011},
                            {32'h0, 4'b0110}, {32'h0, 4'b0110},
                            {32'hFFFFFFFE, 4'b1000}, {32'h80000000, 4'b1000},
                            {32'h0, 4'b0100}, {32'h0000FFFE, 4'b0010}};
    logic [35:0] got;
    logic [35:0] exp;
    for (int i = 0; i < 13; i++) begin
      SrcA = ta[i]; SrcB = tb[i]; ALUcontrol = to[i];
      comb_q.push_back(te[i]);
      #1;
      got = {ALUResult, Negative, Zero, Carry, Overflow};
      exp = comb_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL hand_case_%0d: got res=%h nzcv=%b expected res=%h nzcv=%b",
                 i, got[35:4], got[3:0], exp[35:4], exp[3:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [1:0]  op;
    logic [35:0] got;
    logic [35:0] exp;
    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      b  = (i % 4 == 0) ? a : $urandom;
      op = 2'($urandom_range(0, 3));
      SrcA = a; SrcB = b; ALUcontrol = op;
      comb_q.push_back(model(a, b, op));
      #1;
      got = {ALUResult, Negative, Zero, Carry, Overflow};
      exp = comb_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_%0d: op=%b a=%h b=%h got res=%h nzcv=%b expected res=%h nzcv=%b",
                 i, op, a, b, got[35:4], got[3:0], exp[35:4], exp[3:0]);
      end
    end
  endtask

  task automatic test_flag_reg();
    logic [3:0] exp;
    logic [1:0] fw[4] = '{2'b10, 2'b01, 2'b00, 2'b11};
    logic [3:0] fe[4] = '{4'b1000, 4'b1001, 4'b1001, 4'b0110};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 2) begin SrcA = 32'h7FFFFFFF; SrcB = 32'h7FFFFFFF; ALUcontrol = 2'b10; end
      else       begin SrcA = 32'd7;        SrcB = 32'd7;        ALUcontrol = 2'b11; end
      FlagWrite = fw[i];
      flag_q.push_back(fe[i]);
      @(posedge clk);
      #1;
      exp = flag_q.pop_front();
      checks++;
      if (Flags !== exp) begin
        errors++;
        $display("FAIL flag_step_%0d: got %b expected %b", i, Flags, exp);
      end
    end
    // asynchronous reset between edges
    @(negedge clk);
    #2;
    reset = 1'b1;
    flag_q.push_back(4'b0000);
    #1;
    exp = flag_q.pop_front();
    checks++;
    if (Flags !== exp) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", Flags, exp);
    end
    // reset wins over an edge that would otherwise load 0110
    @(posedge clk);
    #1;
    checks++;
    if (Flags !== 4'b0000) begin
      errors++;
      $display("FAIL reset_priority: got %b expected 0000", Flags);
    end
    // release mid-cycle: no load until next rising edge
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (Flags !== 4'b0000) begin
      errors++;
      $display("FAIL release_no_load: got %b expected 0000", Flags);
    end
    flag_q.push_back(4'b0110);
    @(posedge clk);
    #1;
    exp = flag_q.pop_front();
    checks++;
    if (Flags !== exp) begin
      errors++;
      $display("FAIL load_after_release: got %b expected %b", Flags, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [1:0]  op, fw;
    logic [35:0] r;
    logic [3:0]  mdl;
    logic [3:0]  exp;
    mdl = Flags === 4'b0110 ? 4'b0110 : 4'bxxxx;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom;
      op = 2'($urandom_range(0, 3)); fw = 2'($urandom_range(0, 3));
      SrcA = a; SrcB = b; ALUcontrol = op; FlagWrite = fw;
      r = model(a, b, op);
      if (fw[1]) mdl[3:2] = r[3:2];
      if (fw[0]) mdl[1:0] = r[1:0];
      flag_q.push_back(mdl);
      @(posedge clk);
      #1;
      exp = flag_q.pop_front();
      checks++;
      if (Flags !== exp) begin
        errors++;
        $display("FAIL b2b_%0d: fw=%b op=%b got %b expected %b", i, fw, op, Flags, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hand_cases();
    test_random();
    test_flag_reg();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
